// File: rtl/attempt_display_ctrl.sv
// Attempt counter glue between the BCD attempt counters and the sevenseg decoders:
// death/win edge handling, victory blink, leading-zero blanking, overflow flag and
// an optional fewest-attempts record (built only when ATTEMPT_BEST_SCORE_EN is defined).
module attempt_display_ctrl #(
    parameter int BLINK_HALF    = 6,
    parameter int BLINK_TOGGLES = 8,
    parameter int DEAD_HOLD     = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       death,
    input  logic       win,
    input  logic       menu,
    input  logic [3:0] ones_in,
    input  logic [3:0] tens_in,
    input  logic       tens_cout,
    output logic       attempt_en,
    output logic [3:0] disp_ones,
    output logic [3:0] disp_tens,
    output logic       blank_ones,
    output logic       blank_tens,
    output logic [3:0] best_ones,
    output logic [3:0] best_tens,
    output logic       best_valid,
    output logic       new_best,
    output logic       sat,
    output logic [2:0] state_dbg
);
    localparam int TW = $clog2(DEAD_HOLD + 1);
    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam int CW = $clog2(BLINK_TOGGLES + 1);

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        PLAY      = 3'd1,
        DEAD      = 3'd2,
        WIN_BLINK = 3'd3,
        WIN_HOLD  = 3'd4
    } state_t;

    state_t        state;
    logic          death_q;
    logic          win_q;
    logic [TW-1:0] timer;
    logic [BW-1:0] blink_cnt;
    logic [CW-1:0] toggle_cnt;
    logic [7:0]    snap;
    logic          death_rise;
    logic          win_rise;
    logic          snap_take;

    assign death_rise = death & ~death_q;
    assign win_rise   = win & ~win_q;
    assign snap_take  = win_rise & ((state == PLAY) | (state == DEAD));
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= MENU;
            death_q    <= 1'b0;
            win_q      <= 1'b0;
            timer      <= '0;
            blink_cnt  <= '0;
            toggle_cnt <= '0;
            snap       <= '0;
            sat        <= 1'b0;
            attempt_en <= 1'b0;
            disp_ones  <= '0;
            disp_tens  <= '0;
            blank_ones <= 1'b0;
            blank_tens <= 1'b1;
        end else begin
            death_q    <= death;
            win_q      <= win;
            attempt_en <= 1'b0;
            // The counters see attempt_en and report their carry in the same cycle.
            if (win_rise)
                sat <= 1'b0;
            else if (attempt_en && tens_cout)
                sat <= 1'b1;

            case (state)
                MENU: begin
                    disp_ones  <= ones_in;
                    disp_tens  <= tens_in;
                    blank_ones <= 1'b0;
                    blank_tens <= (tens_in == 4'd0);
                    if (!menu)
                        state <= PLAY;
                end
                PLAY, DEAD: begin
                    if (sat) begin
                        disp_ones  <= 4'd9;
                        disp_tens  <= 4'd9;
                        blank_ones <= 1'b0;
                        blank_tens <= 1'b0;
                    end else begin
                        disp_ones  <= ones_in;
                        disp_tens  <= tens_in;
                        blank_ones <= 1'b0;
                        blank_tens <= (tens_in == 4'd0);
                    end
                    // A win edge beats a simultaneous death edge; the counters clear on
                    // this same edge, so the live digits are captured now.
                    if (snap_take) begin
                        snap       <= {tens_in, ones_in};
                        blink_cnt  <= '0;
                        toggle_cnt <= '0;
                        state      <= WIN_BLINK;
                    end else if (state == PLAY) begin
                        if (death_rise) begin
                            attempt_en <= 1'b1;
                            timer      <= TW'(DEAD_HOLD - 1);
                            state      <= DEAD;
                        end
                    end else if (timer == '0) begin
                        state <= PLAY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WIN_BLINK: begin
                    disp_ones  <= snap[3:0];
                    disp_tens  <= snap[7:4];
                    blank_ones <= ~toggle_cnt[0];
                    blank_tens <= ~toggle_cnt[0] | (snap[7:4] == 4'd0);
                    if (blink_cnt == BW'(BLINK_HALF - 1)) begin
                        blink_cnt  <= '0;
                        toggle_cnt <= toggle_cnt + 1'b1;
                        if (toggle_cnt == CW'(BLINK_TOGGLES - 1))
                            state <= WIN_HOLD;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
                WIN_HOLD: begin
                    disp_ones  <= snap[3:0];
                    disp_tens  <= snap[7:4];
                    blank_ones <= 1'b0;
                    blank_tens <= (snap[7:4] == 4'd0);
                    if (!win)
                        state <= menu ? MENU : PLAY;
                end
                default: state <= MENU;
            endcase
        end
    end

`ifdef ATTEMPT_BEST_SCORE_EN
    logic eval;
    logic snap_sat;

    // Compare one cycle after the win edge, once the snapshot register holds the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            eval       <= 1'b0;
            snap_sat   <= 1'b0;
            best_ones  <= '0;
            best_tens  <= '0;
            best_valid <= 1'b0;
            new_best   <= 1'b0;
        end else begin
            new_best <= 1'b0;
            eval     <= snap_take;
            if (snap_take)
                snap_sat <= sat;
            if (eval && !snap_sat && (!best_valid || (snap < {best_tens, best_ones}))) begin
                best_tens  <= snap[7:4];
                best_ones  <= snap[3:0];
                best_valid <= 1'b1;
                new_best   <= 1'b1;
            end
        end
    end
`else
    assign best_ones  = 4'd0;
    assign best_tens  = 4'd0;
    assign best_valid = 1'b0;
    assign new_best   = 1'b0;
`endif

endmodule

// File: tb/tb_attempt_display_ctrl.sv
// Bench for attempt_display_ctrl: directed vector table, hand-written victory/overflow/reset
// sequences and randomized traffic against an event-time reference model.
module tb_attempt_display_ctrl;
    localparam int BLINK_HALF    = 6;
    localparam int BLINK_TOGGLES = 8;
    localparam int DEAD_HOLD     = 12;
    localparam int BLINK_SPAN    = BLINK_HALF * BLINK_TOGGLES;
`ifdef ATTEMPT_BEST_SCORE_EN
    localparam bit BEST_ON = 1'b1;
`else
    localparam bit BEST_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       death, win, menu, tens_cout;
    logic [3:0] ones_in, tens_in;
    logic       attempt_en, blank_ones, blank_tens, best_valid, new_best, sat;
    logic [3:0] disp_ones, disp_tens, best_ones, best_tens;
    logic [2:0] state_dbg;

    attempt_display_ctrl #(
        .BLINK_HALF(BLINK_HALF), .BLINK_TOGGLES(BLINK_TOGGLES), .DEAD_HOLD(DEAD_HOLD)
    ) dut (
        .clk(clk), .reset(reset), .death(death), .win(win), .menu(menu),
        .ones_in(ones_in), .tens_in(tens_in), .tens_cout(tens_cout),
        .attempt_en(attempt_en), .disp_ones(disp_ones), .disp_tens(disp_tens),
        .blank_ones(blank_ones), .blank_tens(blank_tens), .best_ones(best_ones),
        .best_tens(best_tens), .best_valid(best_valid), .new_best(new_best),
        .sat(sat), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: situation derived from event times rather than counters.
    int         cyc;
    bit         m_in_menu, m_won, m_prev_d, m_prev_w, m_sat, m_cur_att, m_snap_sat, m_best_valid;
    int         m_win_cycle, m_dead_release;
    logic [7:0] m_snap, m_best;
    bit         e_att, e_nb, e_bo, e_bt;
    logic [3:0] e_do, e_dt;
    int         e_state;

    function automatic void model_reset();
        m_in_menu = 1; m_won = 0; m_prev_d = 0; m_prev_w = 0; m_sat = 0; m_cur_att = 0;
        m_snap_sat = 0; m_best_valid = 0; m_win_cycle = 0; m_dead_release = 0;
        m_snap = '0; m_best = '0;
        e_att = 0; e_nb = 0; e_bo = 0; e_bt = 1; e_do = '0; e_dt = '0; e_state = 0;
    endfunction

    function automatic int situation(int n);
        if (m_in_menu) return 0;
        if (m_won) return (n - m_win_cycle <= BLINK_SPAN) ? 3 : 4;
        if (n < m_dead_release) return 2;
        return 1;
    endfunction

    function automatic void predict(bit d, bit w, bit m, logic [3:0] o, logic [3:0] t, bit tc);
        int s;
        int k;
        bit dr, wr, old_sat, dark;
        s = situation(cyc);
        dr = d && !m_prev_d;
        wr = w && !m_prev_w;
        old_sat = m_sat;
        e_att = (s == 1) && dr && !wr;
        e_nb = 0;
        if (s == 0 || ((s == 1 || s == 2) && !old_sat)) begin
            e_do = o; e_dt = t; e_bo = 0; e_bt = (t == 0);
        end else if (s == 1 || s == 2) begin
            e_do = 4'd9; e_dt = 4'd9; e_bo = 0; e_bt = 0;
        end else begin
            k = cyc - m_win_cycle;
            dark = (s == 3) && ((((k - 1) / BLINK_HALF) % 2) == 0);
            e_do = m_snap[3:0]; e_dt = m_snap[7:4]; e_bo = dark; e_bt = dark || (m_snap[7:4] == 0);
        end
        if (BEST_ON && m_won && cyc == m_win_cycle + 1 && !m_snap_sat &&
            (!m_best_valid || m_snap < m_best)) begin
            m_best = m_snap; m_best_valid = 1; e_nb = 1;
        end
        if (wr) m_sat = 0;
        else if (m_cur_att && tc) m_sat = 1;
        if (s == 0) begin
            if (!m) m_in_menu = 0;
        end else if (s == 1 || s == 2) begin
            if (wr) begin
                m_won = 1; m_win_cycle = cyc; m_snap = {t, o}; m_snap_sat = old_sat;
            end else if (s == 1 && dr) begin
                m_dead_release = cyc + DEAD_HOLD + 1;
            end
        end else if (s == 4 && !w) begin
            m_won = 0; m_in_menu = m;
        end
        m_cur_att = e_att; m_prev_d = d; m_prev_w = w;
        cyc++;
        e_state = situation(cyc);
    endfunction

    task automatic compare_model();
        chk("attempt_en", attempt_en, e_att);
        chk("disp_ones", disp_ones, e_do);
        chk("disp_tens", disp_tens, e_dt);
        chk("blank_ones", blank_ones, e_bo);
        chk("blank_tens", blank_tens, e_bt);
        chk("sat", sat, m_sat);
        chk("new_best", new_best, e_nb);
        chk("best_valid", best_valid, BEST_ON ? m_best_valid : 0);
        chk("best_ones", best_ones, BEST_ON ? m_best[3:0] : 0);
        chk("best_tens", best_tens, BEST_ON ? m_best[7:4] : 0);
        chk("state", state_dbg, e_state);
    endtask

    task automatic step(input bit d, input bit w, input bit m, input logic [3:0] o,
                        input logic [3:0] t, input bit tc);
        @(negedge clk);
        death = d; win = w; menu = m; ones_in = o; tens_in = t; tens_cout = tc;
        predict(d, w, m, o, t, tc);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic check_reset_values(string tag);
        chk({tag, "_attempt_en"}, attempt_en, 0);
        chk({tag, "_disp_ones"}, disp_ones, 0);
        chk({tag, "_disp_tens"}, disp_tens, 0);
        chk({tag, "_blank_ones"}, blank_ones, 0);
        chk({tag, "_blank_tens"}, blank_tens, 1);
        chk({tag, "_best"}, {best_valid, best_tens, best_ones, new_best}, 0);
        chk({tag, "_sat"}, sat, 0);
        chk({tag, "_state"}, state_dbg, 0);
    endtask

    // One victory round at digits t:o; exp_best is the record expected afterwards.
    task automatic win_round(input logic [3:0] o, input logic [3:0] t,
                             input logic [7:0] exp_best, input int exp_nb);
        int nb_count = 0;
        int flips = 0;
        bit last_bo = 0;
        step(0, 0, 0, o, t, 0);
        step(0, 1, 0, o, t, 0);
        for (int j = 1; j <= 56; j++) begin
            step(0, 1, 0, 0, 0, 0);
            if (new_best) nb_count++;
            if (j > 1 && blank_ones != last_bo) flips++;
            last_bo = blank_ones;
            if (j == 1) begin
                chk("snap_ones", disp_ones, o);
                chk("snap_tens", disp_tens, t);
                chk("blink_first_dark", blank_ones, 1);
            end
            if (j == 6)  chk("blink_dark_end", blank_ones, 1);
            if (j == 7)  chk("blink_on_start", blank_ones, 0);
            if (j == 7)  chk("blink_on_tens", blank_tens, (t == 0) ? 1 : 0);
            if (j == 13) chk("blink_dark_again", blank_ones, 1);
            if (j == 43) chk("blink_last_on", blank_ones, 0);
            if (j == 47) chk("still_blinking", state_dbg, 3);
            if (j == 48) chk("enter_hold", state_dbg, 4);
            if (j == 56) chk("hold_steady", blank_ones, 0);
        end
        chk("blink_flips", flips, BLINK_TOGGLES - 1);
        chk("new_best_count", nb_count, BEST_ON ? exp_nb : 0);
        chk("best_digits", {best_tens, best_ones}, BEST_ON ? exp_best : 0);
        step(0, 0, 0, 0, 0, 0);
        chk("hold_exit_play", state_dbg, 1);
    endtask

    typedef struct {
        bit d, w, m;
        logic [3:0] o, t;
        bit tc;
        bit att;
        logic [3:0] xo, xt;
        bit xbt;
        logic [2:0] xst;
    } vec_t;

    function automatic vec_t mk(bit d, logic [3:0] o, logic [3:0] t,
                                bit att, bit xbt, logic [2:0] xst);
        vec_t v;
        v.d = d; v.w = 0; v.m = 0; v.o = o; v.t = t; v.tc = 0;
        v.att = att; v.xo = o; v.xt = t; v.xbt = xbt; v.xst = xst;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        vecs[0] = mk(0, 0, 0, 0, 1, 1);
        vecs[1] = mk(1, 7, 0, 1, 1, 2);
        vecs[2] = mk(1, 7, 0, 0, 1, 2);
        vecs[3] = mk(1, 7, 0, 0, 1, 2);
        vecs[4] = mk(0, 7, 1, 0, 0, 2);
        vecs[5] = mk(0, 7, 1, 0, 0, 2);
        vecs[6] = mk(1, 7, 1, 0, 0, 2);
        for (int i = 7; i <= 12; i++) vecs[i] = mk(0, 7, 1, 0, 0, 2);
        vecs[13] = mk(0, 7, 1, 0, 0, 1);
        vecs[14] = mk(1, 8, 1, 1, 0, 2);

        reset = 0; death = 0; win = 0; menu = 0; ones_in = 0; tens_in = 0; tens_cout = 0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        #1 reset = 1;

        foreach (vecs[i]) begin
            step(vecs[i].d, vecs[i].w, vecs[i].m, vecs[i].o, vecs[i].t, vecs[i].tc);
            chk($sformatf("vec%0d_attempt_en", i), attempt_en, vecs[i].att);
            chk($sformatf("vec%0d_disp_ones", i), disp_ones, vecs[i].xo);
            chk($sformatf("vec%0d_disp_tens", i), disp_tens, vecs[i].xt);
            chk($sformatf("vec%0d_blank_tens", i), blank_tens, vecs[i].xbt);
            chk($sformatf("vec%0d_state", i), state_dbg, vecs[i].xst);
        end

        repeat (13) step(0, 0, 0, 4, 2, 0);
        win_round(4, 2, 8'h24, 1);
        win_round(1, 3, 8'h24, 0);
        win_round(9, 0, 8'h09, 1);

        step(0, 0, 0, 5, 5, 0);
        step(1, 1, 0, 5, 5, 0);
        chk("both_edges_attempt_en", attempt_en, 0);
        chk("both_edges_state", state_dbg, 3);
        repeat (55) step(0, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);

        step(0, 0, 0, 9, 9, 1);
        step(1, 0, 0, 9, 9, 1);
        chk("ovf_attempt_en", attempt_en, 1);
        step(1, 0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0, 0);
        chk("ovf_sat", sat, 1);
        chk("ovf_disp", {disp_tens, disp_ones}, 8'h99);
        chk("ovf_blank", {blank_tens, blank_ones}, 0);
        step(0, 1, 0, 0, 0, 0);
        chk("ovf_sat_cleared", sat, 0);
        repeat (10) step(0, 1, 0, 0, 0, 0);
        chk("ovf_best_kept", {best_tens, best_ones}, BEST_ON ? 8'h09 : 0);
        #2 reset = 0;
        #1;
        check_reset_values("midblink_reset");
        model_reset();
        @(posedge clk);
        #2 reset = 1;

        begin
            bit d = 0, w = 0, m = 0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 4) == 0) d = ~d;
                if ($urandom_range(0, 39) == 0) w = ~w;
                if ($urandom_range(0, 29) == 0) m = ~m;
                step(d, w, m, 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     $urandom_range(0, 5) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/attempt_display_ctrl.md
Name: attempt_display_ctrl

Overview:
- Sits between the attempt BCD counters and the two sevenseg decoders, clocked by game_clk.
- Detects death edges and issues a one-cycle attempt-count enable.
- Snapshots the attempt count on victory and blinks it on the displays.
- Blanks the leading-zero tens digit and keeps a best-score (fewest attempts) record.

Parameters:
- BLINK_HALF, 6: game_clk cycles per blink on/off half-period.
- BLINK_TOGGLES, 8: number of half-periods in the victory blink (even value; ends with digits on).
- DEAD_HOLD, 12: cycles after a death edge during which further death edges are ignored.

Ports:
- clk  in  1  game clock (game_clk)
- reset  in  1  asynchronous, active-low reset
- death  in  1  playerDeath level
- win  in  1  victoryScreen level
- menu  in  1  menuScreen level
- ones_in  in  4  attempts ones digit (BCD)
- tens_in  in  4  attempts tens digit (BCD)
- tens_cout  in  1  tens counter carry-out (99 reached)
- attempt_en  out  1  one-cycle attempt-increment pulse to the counters
- disp_ones  out  4  digit to the ones sevenseg
- disp_tens  out  4  digit to the tens sevenseg
- blank_ones  out  1  force ones display dark
- blank_tens  out  1  force tens display dark
- best_ones  out  4  best-score ones digit
- best_tens  out  4  best-score tens digit
- best_valid  out  1  a best score exists
- new_best  out  1  one-cycle pulse when the best score is updated
- sat  out  1  sticky attempt-count overflow flag

Behaviour:
- Reset (reset=0, asynchronous) values:
  - State = MENU.
  - All outputs 0, except blank_tens=1.
  - Snapshot, best, edge registers, timers and sat all cleared.
- Edge detection:
  - death_q and win_q are registered copies of the inputs.
  - Rising edge = input 1 while its registered copy is 0.
- State MENU:
  - Display shows live digits.
  - When menu=0, go to PLAY next cycle.
  - Death edges are ignored.
- State PLAY:
  - Display shows live digits; blank_tens=1 when tens_in==0; blank_ones=0.
  - On a death edge: attempt_en=1 for exactly that one cycle, load hold timer = DEAD_HOLD-1, go to DEAD.
  - On a win edge: snapshot <= {tens_in, ones_in} sampled at that same edge (pre-clear values, because the counters clear on win at the same edge), go to WIN_BLINK.
  - Death edge and win edge in the same cycle: win wins; attempt_en stays 0.
- State DEAD:
  - Live display.
  - Timer decrements each cycle; at 0, go to PLAY.
  - Death edges are ignored.
  - A win edge is handled exactly as in PLAY.
- State WIN_BLINK:
  - disp_* show the snapshot.
  - blank_ones and blank_tens both toggle every BLINK_HALF cycles, starting dark.
  - After BLINK_TOGGLES half-periods, go to WIN_HOLD with digits on.
  - Tens leading-zero blanking applies whenever the digits are on.
- State WIN_HOLD:
  - Snapshot shown steady.
  - When win=0, go to MENU if menu=1, else PLAY.
- sat:
  - Set when tens_cout=1 with attempt_en=1.
  - Cleared on a win edge or reset.
  - While sat=1 in PLAY or DEAD, the display is forced to 9/9 with no blanking.
- Best update, evaluated on the cycle after the win edge:
  - Update when best_valid=0, or the snapshot is lexicographically (tens, then ones) less than best.
  - On update: best <= snapshot, best_valid=1, new_best=1 for one cycle.
  - Snapshot 00 is legal.
  - A snapshot taken while sat=1 never updates best.
- Asserting reset mid-blink immediately returns to MENU and discards the snapshot.
- All comparisons are 4-bit unsigned per digit; inputs are assumed BCD-valid 0–9.

Optional Feature:
- Macro: ATTEMPT_BEST_SCORE_EN.
- Defined: best register, compare logic, best_ones, best_tens, best_valid and new_best behave as above.
- Undefined: that logic is not built; best_ones, best_tens, best_valid and new_best are tied 0. All other behaviour is unchanged.

Test Plan:
- Release reset, menu=0, raise death for 3 cycles → attempt_en=1 for exactly 1 cycle. A second death pulse 5 cycles later → no attempt_en. A pulse 13 cycles after the first edge → attempt_en=1.
- ones_in=7, tens_in=0 in PLAY → disp_ones=7, blank_tens=1. tens_in=1 → blank_tens=0.
- ones_in=4, tens_in=2, then win edge (inputs cleared next cycle) → snapshot 24 displayed. Blank toggles every 6 cycles for 48 cycles, then steady. With the macro on: best=24, new_best pulses once.
- Next round wins at 31 → best stays 24, no new_best. Following round wins at 09 → best=09, new_best=1.
- death and win rising in the same cycle → attempt_en=0, state enters WIN_BLINK.
- tens_cout=1 with a death edge → sat=1 and display shows 99. Drop reset during WIN_BLINK → all outputs at reset values, state MENU.
